pic_int_ack_ctrl: RTL

- Interrupt-side core of the 8259-style PIC. It sits directly downstream of the read/write control logic and consumes its ICW2/ICW4/ICW1/OCW1/OCW2 fields.
- Holds the IRR, ISR and priority logic, and drives INT to the CPU.
- Runs the two-pulse 8086 INTA sequence and presents the 8-bit vector to the data bus buffer.

---
 rtl/pic_pkg.sv | 27 ++
 rtl/pic_priority_resolver.sv | 24 ++
 rtl/pic_int_ack_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, constants and priority helper for the PIC interrupt core
package pic_pkg;

    localparam int IR_W = 8;
    localparam int LVL_W = 3;
    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } pic_state_t;

    // Returns {valid, level} of the lowest-index (highest-priority) set bit.
    function automatic logic [LVL_W:0] highest_pri(input logic [IR_W-1:0] v);
        logic [LVL_W:0] r;
        r = '0;
        for (int i = IR_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, i[LVL_W-1:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - fixed-priority, fully nested request resolver
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [IR_W-1:0]  irr,
    input  logic [IR_W-1:0]  imr,
    input  logic [IR_W-1:0]  isr,
    output logic             pending,
    output logic [LVL_W-1:0] req_lvl
);

    logic [LVL_W:0] cand_hp;
    logic [LVL_W:0] isr_hp;

    // A request only interrupts the CPU if it outranks everything in service.
    always_comb begin
        cand_hp = highest_pri(irr & ~imr);
        isr_hp  = highest_pri(isr);
        req_lvl = cand_hp[LVL_W-1:0];
        pending = cand_hp[LVL_W] &&
                  (!isr_hp[LVL_W] || (cand_hp[LVL_W-1:0] < isr_hp[LVL_W-1:0]));
    end

endmodule

// File: rtl/pic_int_ack_ctrl.sv
// rtl/pic_int_ack_ctrl.sv - IRR/ISR, INT generation and two-pulse INTA vector sequencer
module pic_int_ack_ctrl
    import pic_pkg::*;
#(
    parameter int NUM_IR   = 8,
    parameter int VEC_HI_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IR-1:0]         ir,
    input  logic                      ltim,
    input  logic [VEC_HI_W-1:0]       icw2_vec,
    input  logic                      aeoi,
    input  logic [NUM_IR-1:0]         imr,
    input  logic                      init_busy,
    input  logic                      eoi_ns,
    input  logic                      eoi_sp,
    input  logic [LVL_W-1:0]          eoi_lvl,
    input  logic                      inta_n,
    output logic                      intr,
    output logic [VEC_HI_W+LVL_W-1:0] vec_out,
    output logic                      vec_oe,
    output logic [NUM_IR-1:0]         irr,
    output logic [NUM_IR-1:0]         isr
);

    pic_state_t        state;
    pic_state_t        state_nx;
    logic [NUM_IR-1:0] ir_prev;
    logic              inta_prev;
    logic [LVL_W-1:0]  sel;
    logic              spurious;

    logic              pending;
    logic [LVL_W-1:0]  req_lvl;
    logic              inta_fall;
    logic              inta_rise;
    logic              ack_start;
    logic              vec_load;
    logic              ack_end;

    logic [LVL_W:0]    isr_hp;
    logic [NUM_IR-1:0] eoi_clr;
    logic [NUM_IR-1:0] aeoi_clr;
    logic [NUM_IR-1:0] ack_set;
    logic [NUM_IR-1:0] irr_base;
    logic [NUM_IR-1:0] irr_nx;
    logic [NUM_IR-1:0] isr_nx;

    pic_priority_resolver u_resolver (
        .irr     (irr),
        .imr     (imr),
        .isr     (isr),
        .pending (pending),
        .req_lvl (req_lvl)
    );

    assign inta_fall = inta_prev & ~inta_n;
    assign inta_rise = ~inta_prev & inta_n;

    // INTA sequencer: next state plus one-cycle action strobes for the datapath.
    always_comb begin
        state_nx  = state;
        ack_start = 1'b0;
        vec_load  = 1'b0;
        ack_end   = 1'b0;
        case (state)
            IDLE: begin
                if (inta_fall) begin
                    ack_start = 1'b1;
                    state_nx  = ACK1;
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (inta_fall) begin
                    vec_load = 1'b1;
                    state_nx = ACK2;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    ack_end  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sequencer state register; init_busy forces it home.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (init_busy) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next IRR/ISR: EOI and auto-EOI clears first, then the acknowledge set.
    always_comb begin
        isr_hp   = highest_pri(isr);
        eoi_clr  = '0;
        aeoi_clr = '0;
        ack_set  = '0;
        if (eoi_sp) begin
            eoi_clr[eoi_lvl] = 1'b1;
        end else if (eoi_ns && isr_hp[LVL_W]) begin
            eoi_clr[isr_hp[LVL_W-1:0]] = 1'b1;
        end
        if (ack_end && aeoi && !spurious) begin
            aeoi_clr[sel] = 1'b1;
        end
        if (ack_start && pending) begin
            ack_set[req_lvl] = 1'b1;
        end
        isr_nx   = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
        irr_base = ltim ? ir : (irr | (ir & ~ir_prev));
        irr_nx   = irr_base & ~ack_set;
    end

    // Request/service registers, INT output and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irr       <= '0;
            isr       <= '0;
            intr      <= 1'b0;
            ir_prev   <= '1;
            inta_prev <= 1'b1;
        end else begin
            inta_prev <= inta_n;
            ir_prev   <= ir;
            if (init_busy) begin
                irr  <= '0;
                isr  <= '0;
                intr <= 1'b0;
            end else begin
                irr  <= irr_nx;
                isr  <= isr_nx;
                intr <= (state == IDLE) && pending && !ack_start;
            end
        end
    end

    // Acknowledge bookkeeping and vector presentation to the data bus buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            spurious <= 1'b0;
            vec_out  <= '0;
            vec_oe   <= 1'b0;
        end else if (init_busy) begin
            vec_oe <= 1'b0;
        end else begin
            if (ack_start) begin
                sel      <= pending ? req_lvl : SPURIOUS_LVL;
                spurious <= !pending;
            end
            if (vec_load) begin
                vec_out <= {icw2_vec, sel};
                vec_oe  <= 1'b1;
            end
            if (ack_end) begin
                vec_oe <= 1'b0;
            end
        end
    end

endmodule
